// File: rtl/transmit_state_machine_pkg.sv
// rtl/transmit_state_machine_pkg.sv - shared eUSCI UART state encodings, line levels and bit-order helper
package transmit_state_machine_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP1  = 3'd5,
        STOP2  = 3'd6
    } uart_state_t;

    localparam logic STARTBIT = 1'b0;
    localparam logic STOPBIT  = 1'b1;
    localparam logic PAR_ODD  = 1'b0;
    localparam logic PAR_EVEN = 1'b1;

    // Arranges the character so the next bit on the line is always bit 0.
    function automatic logic [7:0] tx_order(input logic [7:0] d, input logic msb, input logic b7);
        logic [7:0] m;
        logic [7:0] r;
        m = b7 ? {1'b0, d[6:0]} : d;
        for (int i = 0; i < 8; i++) begin
            r[i] = m[7-i];
        end
        if (!msb) begin
            return m;
        end
        return b7 ? {1'b0, r[7:1]} : r;
    endfunction

endpackage

// File: rtl/transmit_state_machine_tx_parity_gen.sv
// rtl/transmit_state_machine_tx_parity_gen.sv - combinational odd/even parity over 7 or 8 data bits
module tx_parity_gen
    import transmit_state_machine_pkg::*;
(
    input  logic [7:0] data,
    input  logic       b7,
    input  logic       par,
    output logic       parity
);

    logic [7:0] masked;

    assign masked = b7 ? {1'b0, data[6:0]} : data;
    assign parity = (^masked) ^ (par == PAR_ODD);

endmodule

// File: rtl/transmit_state_machine.sv
// rtl/transmit_state_machine.sv - eUSCI UART transmit engine; TX_BREAK_EN enables break frames via wUCTXBRK
module transmit_state_machine
    import transmit_state_machine_pkg::*;
(
    input  logic       MCLK,
    input  logic       reset,
    input  logic       BITCLK,
    input  logic       wUCPEN,
    input  logic       wUCPAR,
    input  logic       wUCMSB,
    input  logic       wUC7BIT,
    input  logic       wUCSPB,
`ifdef TX_BREAK_EN
    input  logic       wUCTXBRK,
`endif
    input  logic [7:0] TxData,
    input  logic       TxIFG,
    output logic       Tx,
    output logic       TxBEN,
    output logic       rSetTxIFG,
    output logic       TxBusy
);

    uart_state_t state, state_n;

    logic       bitclk_d;
    logic       tick;
    logic       tx, tx_n;
    logic       txben, txben_n;
    logic       busy, busy_n;
    logic       set_ifg, set_ifg_n;
    logic [2:0] bitcnt, bitcnt_n;
    logic [7:0] shreg;
    logic       latch, shift, eof;
    logic       pen_l, b7_l, spb_l, brk_l, parity_l;
    logic       brk_in, parity_in;
    logic [2:0] last_bit;

`ifdef TX_BREAK_EN
    assign brk_in = wUCTXBRK;
`else
    assign brk_in = 1'b0;
`endif

    tx_parity_gen u_parity (
        .data   (TxData),
        .b7     (wUC7BIT),
        .par    (wUCPAR),
        .parity (parity_in)
    );

    assign last_bit = b7_l ? 3'd6 : 3'd7;

    // Registered edge detect: the tick lands one MCLK after BITCLK is seen high.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            bitclk_d <= 1'b0;
            tick     <= 1'b0;
        end else begin
            bitclk_d <= BITCLK;
            tick     <= BITCLK & ~bitclk_d;
        end
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= STOPBIT;
            txben    <= 1'b0;
            busy     <= 1'b0;
            set_ifg  <= 1'b0;
            bitcnt   <= 3'd0;
            shreg    <= 8'd0;
            pen_l    <= 1'b0;
            b7_l     <= 1'b0;
            spb_l    <= 1'b0;
            brk_l    <= 1'b0;
            parity_l <= 1'b0;
        end else begin
            state   <= state_n;
            tx      <= tx_n;
            txben   <= txben_n;
            busy    <= busy_n;
            set_ifg <= set_ifg_n;
            bitcnt  <= bitcnt_n;
            if (latch) begin
                shreg    <= tx_order(TxData, wUCMSB, wUC7BIT);
                pen_l    <= wUCPEN;
                b7_l     <= wUC7BIT;
                spb_l    <= wUCSPB;
                brk_l    <= brk_in;
                parity_l <= parity_in;
            end else if (shift) begin
                shreg <= {1'b0, shreg[7:1]};
            end
        end
    end

    always_comb begin
        state_n   = state;
        tx_n      = tx;
        txben_n   = txben;
        busy_n    = busy;
        set_ifg_n = 1'b0;
        bitcnt_n  = bitcnt;
        latch     = 1'b0;
        shift     = 1'b0;
        eof       = 1'b0;

        case (state)
            IDLE: begin
                tx_n = STOPBIT;
                if (!TxIFG) begin
                    latch     = 1'b1;
                    set_ifg_n = 1'b1;
                    txben_n   = 1'b1;
                    busy_n    = 1'b1;
                    state_n   = LOAD;
                end
            end
            LOAD: begin
                if (tick) begin
                    state_n = START;
                    tx_n    = STARTBIT;
                end
            end
            START: begin
                if (tick) begin
                    state_n  = DATA;
                    bitcnt_n = 3'd0;
                    tx_n     = shreg[0] & ~brk_l;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bitcnt == last_bit) begin
                        if (pen_l) begin
                            state_n = PARITY;
                            tx_n    = parity_l & ~brk_l;
                        end else begin
                            state_n = STOP1;
                            tx_n    = STOPBIT;
                        end
                    end else begin
                        bitcnt_n = bitcnt + 3'd1;
                        shift    = 1'b1;
                        tx_n     = shreg[1] & ~brk_l;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_n = STOP1;
                    tx_n    = STOPBIT;
                end
            end
            STOP1: begin
                if (tick) begin
                    if (spb_l) begin
                        state_n = STOP2;
                        tx_n    = STOPBIT;
                    end else begin
                        eof = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (tick) begin
                    eof = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = STOPBIT;
                txben_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase

        // Chaining skips LOAD so the next start bit follows the last stop bit directly.
        if (eof) begin
            if (!TxIFG) begin
                latch     = 1'b1;
                set_ifg_n = 1'b1;
                state_n   = START;
                tx_n      = STARTBIT;
            end else begin
                state_n = IDLE;
                tx_n    = STOPBIT;
                txben_n = 1'b0;
                busy_n  = 1'b0;
            end
        end
    end

    assign Tx        = tx;
    assign TxBEN     = txben;
    assign rSetTxIFG = set_ifg;
    assign TxBusy    = busy;

endmodule

// File: tb/tb_transmit_state_machine.sv
// tb/tb_transmit_state_machine.sv - self-checking bench for transmit_state_machine
module tb_transmit_state_machine;

    localparam int P = 16;

    logic       MCLK = 1'b0;
    logic       reset = 1'b1;
    logic       BITCLK = 1'b0;
    logic       wUCPEN = 1'b0;
    logic       wUCPAR = 1'b0;
    logic       wUCMSB = 1'b0;
    logic       wUC7BIT = 1'b0;
    logic       wUCSPB = 1'b0;
`ifdef TX_BREAK_EN
    logic       wUCTXBRK = 1'b0;
`endif
    logic [7:0] TxData = 8'h00;
    logic       TxIFG = 1'b1;
    logic       Tx, TxBEN, rSetTxIFG, TxBusy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int ben_gaps = 0;

    transmit_state_machine dut (
        .MCLK      (MCLK),
        .reset     (reset),
        .BITCLK    (BITCLK),
        .wUCPEN    (wUCPEN),
        .wUCPAR    (wUCPAR),
        .wUCMSB    (wUCMSB),
        .wUC7BIT   (wUC7BIT),
        .wUCSPB    (wUCSPB),
`ifdef TX_BREAK_EN
        .wUCTXBRK  (wUCTXBRK),
`endif
        .TxData    (TxData),
        .TxIFG     (TxIFG),
        .Tx        (Tx),
        .TxBEN     (TxBEN),
        .rSetTxIFG (rSetTxIFG),
        .TxBusy    (TxBusy)
    );

    always #5 MCLK = ~MCLK;

    initial begin
        forever begin
            repeat (P/2) @(negedge MCLK);
            BITCLK = ~BITCLK;
        end
    end

    // Register-side behaviour: the consumed pulse sets TXIFG.
    initial begin
        forever begin
            @(posedge MCLK);
            #1;
            if (rSetTxIFG === 1'b1) TxIFG = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge MCLK);
            if (rSetTxIFG === 1'b1) pulses++;
            if (TxBusy === 1'b1 && TxBEN !== 1'b1) ben_gaps++;
        end
    end

    // Reference frame: start, data bits in line order, parity, stop bits.
    task automatic model(input logic [7:0] d, input logic pen, input logic par, input logic msb,
                         input logic b7, input logic spb, input logic brk,
                         output logic [31:0] seq, output int len);
        logic q[$];
        logic bits[$];
        int n, ones;
        n = b7 ? 7 : 8;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            bits.push_back(d[i]);
            ones += d[i];
        end
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) q.push_back(brk ? 1'b0 : bits[msb ? n-1-i : i]);
        if (pen) q.push_back(brk ? 1'b0 : (par ? ((ones % 2) == 1) : ((ones % 2) == 0)));
        q.push_back(1'b1);
        if (spb) q.push_back(1'b1);
        seq = 32'd0;
        foreach (q[i]) seq = {seq[30:0], q[i]};
        len = q.size();
    endtask

    task automatic set_fmt(input logic pen, input logic par, input logic msb, input logic b7, input logic spb);
        wUCPEN = pen; wUCPAR = par; wUCMSB = msb; wUC7BIT = b7; wUCSPB = spb;
    endtask

    task automatic start_frame(input logic [7:0] d);
        repeat ($urandom_range(1, P)) @(negedge MCLK);
        TxData = d;
        TxIFG  = 1'b0;
    endtask

    task automatic check_frame(input logic [31:0] seq, input int len, input string name);
        bit found;
        found = 0;
        for (int c = 0; c < 4*P; c++) begin
            @(negedge MCLK);
            if (Tx === 1'b0) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s start bit not seen got Tx=%b want 0", name, Tx);
            return;
        end
        for (int i = 0; i < len; i++) begin
            repeat (i == 0 ? P/2 : P) @(negedge MCLK);
            checks++;
            if (Tx !== seq[len-1-i]) begin
                errors++;
                $display("FAIL %s bit %0d got %b want %b", name, i, Tx, seq[len-1-i]);
            end
        end
        repeat (P/2 - 2) @(negedge MCLK);
        checks++;
        if (TxBusy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy before end got %b want 1", name, TxBusy);
        end
        repeat (4) @(negedge MCLK);
        checks++;
        if ({Tx, TxBEN, TxBusy} !== 3'b100) begin
            errors++;
            $display("FAIL %s idle after end got Tx/BEN/Busy=%b want 100", name, {Tx, TxBEN, TxBusy});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge MCLK);
        checks++;
        if ({Tx, TxBEN, rSetTxIFG, TxBusy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset outputs got %b want 1000", {Tx, TxBEN, rSetTxIFG, TxBusy});
        end
        reset = 1'b0;
        repeat (2*P) @(negedge MCLK);
        checks++;
        if ({Tx, TxBEN, TxBusy} !== 3'b100 || pulses != 0) begin
            errors++;
            $display("FAIL reset idle got %b pulses %0d want 100 pulses 0", {Tx, TxBEN, TxBusy}, pulses);
        end
    endtask

    task automatic test_directed(input logic [7:0] d, input logic pen, input logic par, input logic msb,
                                 input logic b7, input logic spb, input logic [31:0] seq, input int len,
                                 input string name);
        int p0;
        set_fmt(pen, par, msb, b7, spb);
        p0 = pulses;
        start_frame(d);
        check_frame(seq, len, name);
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL %s pulses got %0d want 1", name, pulses - p0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] s1, s2, seq;
        int l1, l2, p0, g0;
        set_fmt(0, 0, 0, 0, 0);
        model(8'h12, 0, 0, 0, 0, 0, 0, s1, l1);
        model(8'h5E, 0, 0, 0, 0, 0, 0, s2, l2);
        seq = (s1 << l2) | s2;
        p0 = pulses;
        g0 = ben_gaps;
        start_frame(8'h12);
        fork
            check_frame(seq, l1 + l2, "back_to_back");
            begin
                repeat (4*P) @(negedge MCLK);
                TxData = 8'h5E;
                TxIFG  = 1'b0;
            end
        join
        checks++;
        if (pulses - p0 != 2 || ben_gaps != g0) begin
            errors++;
            $display("FAIL back_to_back pulses got %0d want 2, ben gaps got %0d want 0", pulses - p0, ben_gaps - g0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        bit found;
        set_fmt(1, 1, 0, 0, 1);
        p0 = pulses;
        start_frame(8'($urandom));
        found = 0;
        for (int c = 0; c < 4*P; c++) begin
            @(negedge MCLK);
            if (Tx === 1'b0) begin
                found = 1;
                break;
            end
        end
        repeat (P + P/2) @(negedge MCLK);
        reset = 1'b1;
        @(negedge MCLK);
        checks++;
        if (!found || {Tx, TxBEN, TxBusy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid got start %0d outputs %b want 1 and 100", found, {Tx, TxBEN, TxBusy});
        end
        reset = 1'b0;
        repeat (3*P) @(negedge MCLK);
        checks++;
        if ({Tx, TxBEN, TxBusy} !== 3'b100 || pulses - p0 != 1) begin
            errors++;
            $display("FAIL reset_mid idle got %b pulses %0d want 100 pulses 1", {Tx, TxBEN, TxBusy}, pulses - p0);
        end
    endtask

    task automatic test_random();
        logic [31:0] seq;
        int len;
        logic [7:0] d;
        logic pen, par, msb, b7, spb;
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            pen = 1'($urandom); par = 1'($urandom); msb = 1'($urandom);
            b7 = 1'($urandom); spb = 1'($urandom);
            set_fmt(pen, par, msb, b7, spb);
            model(d, pen, par, msb, b7, spb, 1'b0, seq, len);
            start_frame(d);
            check_frame(seq, len, $sformatf("random%0d_%02h_%b", k, d, {pen, par, msb, b7, spb}));
        end
    endtask

`ifdef TX_BREAK_EN
    task automatic test_break();
        logic [31:0] seq;
        int len;
        set_fmt(1, 1, 0, 0, 0);
        wUCTXBRK = 1'b1;
        model(8'hFF, 1, 1, 0, 0, 0, 1'b1, seq, len);
        start_frame(8'hFF);
        repeat (3) @(negedge MCLK);
        wUCTXBRK = 1'b0;
        check_frame(seq, len, "break");
    endtask
`endif

    initial begin
        test_reset();
        test_directed(8'hA5, 0, 0, 0, 0, 0, 32'b0101001011,   10, "8N1_A5");
        test_directed(8'h55, 1, 0, 0, 0, 1, 32'b010101010111, 12, "8O2_55");
        test_directed(8'h34, 1, 1, 1, 0, 0, 32'b00011010011,  11, "8E1_MSB_34");
        test_directed(8'hB5, 1, 0, 1, 1, 1, 32'b00110101111,  11, "7O2_MSB_35");
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
`ifdef TX_BREAK_EN
        test_break();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/transmit_state_machine.md
# transmit_state_machine

eUSCI UART transmit engine: serialises one character from the transmit buffer onto the Tx line as start bit, 7/8 data bits (LSB or MSB first), optional parity and 1/2 stop bits. Sits between the UCAxTXBUF/IFG register logic and the baud-rate generator, mirroring the receive engine's control inputs. It paces bits from the baud-rate generator's BITCLK, sampled in the MCLK domain.

## Interface
Parameters:
- None. Frame format comes from control inputs.

Ports:
- MCLK  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high (SWRST).
- BITCLK  input  1  bit clock from the baud-rate generator; sampled on MCLK and rising-edge detected.
- wUCPEN  input  1  parity enable.
- wUCPAR  input  1  parity select: 0 = odd, 1 = even.
- wUCMSB  input  1  1 = MSB first.
- wUC7BIT  input  1  1 = 7-bit data (TxData[6:0]).
- wUCSPB  input  1  1 = two stop bits.
- wUCTXBRK  input  1  next frame is a break (exists only with TX_BREAK_EN).
- TxData  input  8  transmit buffer contents.
- TxIFG  input  1  current TXIFG; 0 = buffer holds unsent data.
- Tx  output  1  serial line; idle high.
- TxBEN  output  1  request to the baud-rate generator to run BITCLK.
- rSetTxIFG  output  1  one-MCLK pulse: buffer consumed, set TXIFG.
- TxBusy  output  1  high from load until the last stop bit ends.

## Operation
- Reset values: Tx=1, TxBEN=0, rSetTxIFG=0, TxBusy=0, state IDLE, shift register 0.
- tick = BITCLK high now and low on the previous MCLK sample (one-MCLK pulse).
- States: IDLE, LOAD, START, DATA, PARITY, STOP1, STOP2.
- IDLE: when TxIFG=0, latch TxData plus PEN/PAR/MSB/7BIT/SPB/TXBRK into internal registers. Pulse rSetTxIFG. Set TxBEN=1 and TxBusy=1. Go to LOAD.
- Control inputs are ignored mid-frame; only the latched copy is used.
- LOAD → START on tick; Tx=0.
- START → DATA on tick. Data bit count N = 7 or 8; bit counter runs 0..N-1.
  - LSB first: bit i.
  - MSB first: bit N-1-i (7-bit MSB sends bit 6 first).
- DATA → PARITY on the tick after the last data bit if PEN=1, else → STOP1.
- Parity bit = XOR of the N data bits, inverted when odd (PAR=0). Total ones (data + parity) is odd for odd parity, even for even parity.
- STOP1 (Tx=1) → STOP2 on tick if SPB=1. Otherwise end-of-frame. STOP2 (Tx=1) → end-of-frame on tick.
- End-of-frame:
  - If TxIFG=0: re-latch and pulse rSetTxIFG, then go directly to START on the same tick (back-to-back, no idle bit).
  - Otherwise go to IDLE with TxBEN=0, TxBusy=0, Tx=1.
- Break: data bits and parity bit are forced 0; stop bits stay 1.
- reset asserted in any state forces reset values on the next MCLK edge. A partially sent frame is abandoned and TXIFG is not touched.

## Timing
- tick is registered: Tx changes on the MCLK edge after the BITCLK rising edge is sampled (2 MCLK latency from the raw BITCLK rise).
- Each bit occupies exactly one BITCLK period.
- rSetTxIFG fires one MCLK after TxIFG is seen low in IDLE, and at end-of-frame when chaining.
- Load to start bit: up to one BITCLK period plus 2 MCLK.
- Frame length in BITCLK periods = 1 + N + PEN + 1 + SPB (min 9, max 12).
- TxIFG low in the same MCLK as a tick in IDLE: load takes priority; the start bit waits for the next tick.

## Configuration
- TX_BREAK_EN defined: wUCTXBRK port present; break frames supported as above.
- TX_BREAK_EN undefined: port absent; latched break flag tied 0; all frames carry TxData.

## Structure
- Shared eUSCI package/include holds:
  - state encodings (IDLE..STOP2)
  - STARTBIT=0, STOPBIT=1
  - the odd/even parity select constant
  - both state machines use it.
- One natural sub-module, tx_parity_gen: combinational N-bit parity with odd/even select and 7BIT masking; reusable by the receive engine's check.

## Test plan
- 8N1, LSB, TxData=0xA5: Tx = 0,1,0,1,0,0,1,0,1,1, one BITCLK each. Exactly one rSetTxIFG pulse; TxBusy drops after the stop bit.
- 8O2, LSB, 0x55: Tx = 0,1,0,1,0,1,0,1,0,1(parity),1,1. Frame is 12 BITCLK periods.
- 8E1, MSB, 0x34: Tx = 0,0,0,1,1,0,1,0,0,1(parity),1.
- 7O2, MSB, 0x35: Tx = 0,0,1,1,0,1,0,1,1(parity),1,1. Check 7BIT masking.
- Back-to-back: 0x12 then 0x5E with TxIFG re-cleared mid-frame.
  - Second start bit immediately follows the first stop bit.
  - Two rSetTxIFG pulses; TxBEN never drops.
- reset asserted during the DATA state: Tx=1, TxBEN=0, TxBusy=0 on the next MCLK. With TX_BREAK_EN, a break frame sends 0 for the start bit, all data bits and parity, then stop=1.
